buf_id_arbiter: RTL and testbench

BUF_ID_ARBITER -- requirements
Module: buf_id_arbiter

---
 rtl/buf_id_arbiter_if.sv | 22 ++
 rtl/buf_id_arbiter.sv | 131 +++++++++++++
 tb/tb_buf_id_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buf_id_arbiter_if.sv
// rtl/buf_id_arbiter_if.sv - request/grant and release bundle for the buffer ID arbiter
interface buf_id_arbiter_if;
    logic [3:0]  in_req;
    logic [3:0]  out_gnt;
    logic [3:0]  out_gnt_id;
    logic [10:0] out_gnt_addr;
    logic        in_rel_wr;
    logic [3:0]  in_rel_id;
    logic [4:0]  out_free_count;
    logic        out_rel_err;
    logic [15:0] out_busy_map;

    modport slave (
        input  in_req, in_rel_wr, in_rel_id,
        output out_gnt, out_gnt_id, out_gnt_addr, out_free_count, out_rel_err, out_busy_map
    );

    modport master (
        output in_req, in_rel_wr, in_rel_id,
        input  out_gnt, out_gnt_id, out_gnt_addr, out_free_count, out_rel_err, out_busy_map
    );
endinterface

// File: rtl/buf_id_arbiter.sv
// rtl/buf_id_arbiter.sv - round-robin ingress arbiter allocating lowest-free buffer IDs
module buf_id_arbiter #(
    parameter string PLATFORM = "xilinx",
    parameter int    ID_NUM   = 16
) (
    input logic             clk,
    input logic             rst_n,
    buf_id_arbiter_if.slave bus
);

    if (ID_NUM != 16 || PLATFORM == "") begin : g_bad_param
        $error("buf_id_arbiter supports exactly 16 buffer IDs");
    end

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT  = 2'b01,
        ARB_WAIT = 2'b10
    } arb_state_t;

    arb_state_t  state, state_n;
    logic [15:0] busy, busy_n;
    logic [1:0]  rr_ptr, rr_n;
    logic [1:0]  winner, winner_n;
    logic [3:0]  gnt, gnt_n;
    logic [3:0]  gnt_id, gnt_id_n;
    logic        rel_err, rel_err_n;

    logic [1:0]  pick, cand;
    logic        pick_found;
    logic [3:0]  low_id;
    logic        low_found;
    logic        alloc;
    logic        rel_hit;
    logic [15:0] rel_mask, alloc_mask;

    // Round-robin search over the four ingress ports starting at rr_ptr.
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!pick_found && bus.in_req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Lowest free ID, taken from the registered (pre-release) bitmap.
    always_comb begin
        low_id    = '0;
        low_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!low_found && !busy[i]) begin
                low_id    = 4'(i);
                low_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        alloc    = 1'b0;
        gnt_n    = '0;
        gnt_id_n = gnt_id;
        winner_n = winner;
        rr_n     = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (pick_found && low_found) begin
                    alloc    = 1'b1;
                    winner_n = pick;
                    gnt_n    = 4'b0001 << pick;
                    gnt_id_n = low_id;
                    state_n  = ARB_GNT;
                end
            end
            ARB_GNT: begin
                rr_n    = winner + 2'd1;
                state_n = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (!bus.in_req[winner]) begin
                    state_n = ARB_IDLE;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // A release of a free ID (including the one being allocated now) is only flagged.
    always_comb begin
        rel_hit    = bus.in_rel_wr && busy[bus.in_rel_id];
        rel_err_n  = bus.in_rel_wr && !busy[bus.in_rel_id];
        rel_mask   = rel_hit ? (16'b1 << bus.in_rel_id) : 16'b0;
        alloc_mask = alloc ? (16'b1 << low_id) : 16'b0;
        busy_n     = (busy & ~rel_mask) | alloc_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            busy    <= '0;
            rr_ptr  <= '0;
            winner  <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            rel_err <= 1'b0;
        end else begin
            state   <= state_n;
            busy    <= busy_n;
            rr_ptr  <= rr_n;
            winner  <= winner_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            rel_err <= rel_err_n;
        end
    end

    assign bus.out_gnt        = gnt;
    assign bus.out_gnt_id     = gnt_id;
    assign bus.out_gnt_addr   = {gnt_id, 7'h0};
    assign bus.out_free_count = 5'd16 - 5'($countones(busy));
    assign bus.out_rel_err    = rel_err;
    assign bus.out_busy_map   = busy;

endmodule

// File: tb/tb_buf_id_arbiter.sv
// tb/tb_buf_id_arbiter.sv - scoreboard bench for buf_id_arbiter with a pool-level reference model
module tb_buf_id_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    buf_id_arbiter_if bus ();

    buf_id_arbiter #(.PLATFORM("xilinx"), .ID_NUM(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] id;
        logic [4:0] free;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [15:0] mb;
    int          rr;
    logic [3:0]  last_id;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 16; i++) if (!mb[i]) return i;
        return -1;
    endfunction

    function automatic int free_cnt();
        return 16 - $countones(mb);
    endfunction

    // Pool-level prediction: each requester is served once, in round-robin order.
    task automatic predict(input logic [3:0] m);
        logic [3:0] pend = m;
        exp_t e;
        while (pend != 0) begin
            int p = -1;
            int id;
            for (int k = 0; k < 4; k++) if (p < 0 && pend[(rr + k) % 4]) p = (rr + k) % 4;
            id = lowest_free();
            mb[id] = 1'b1;
            e.gnt = 4'(1 << p);
            e.id = 4'(id);
            e.free = 5'(free_cnt());
            q.push_back(e);
            last_id = 4'(id);
            pend[p] = 1'b0;
            rr = (p + 1) % 4;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_gnt != 4'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_gnt", 32'(bus.out_gnt), 32'h0);
            end else begin
                me = q.pop_front();
                chk("gnt_port", 32'(bus.out_gnt), 32'(me.gnt));
                chk("gnt_id", 32'(bus.out_gnt_id), 32'(me.id));
                chk("gnt_addr", 32'(bus.out_gnt_addr), 32'(me.id) * 128);
                chk("gnt_free", 32'(bus.out_free_count), 32'(me.free));
            end
        end
    end

    task automatic drain(input int maxc);
        int cyc = 0;
        while (bus.in_req != 0 && cyc < maxc) begin
            if (bus.out_gnt != 0) bus.in_req = bus.in_req & ~bus.out_gnt;
            if (bus.in_req != 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (bus.in_req != 0) begin
            chk("drain_timeout", 32'(bus.in_req), 32'h0);
            bus.in_req = '0;
        end
    endtask

    task automatic run_round(input logic [3:0] m);
        predict(m);
        @(negedge clk);
        bus.in_req = m;
        @(negedge clk);
        chk("first_gnt_latency", 32'(bus.out_gnt != 0), 32'h1);
        drain(200);
        repeat (3) @(negedge clk);
        chk("round_busy_map", 32'(bus.out_busy_map), 32'(mb));
        chk("round_free", 32'(bus.out_free_count), 32'(free_cnt()));
        chk("gnt_id_hold", 32'(bus.out_gnt_id), 32'(last_id));
        chk("gnt_addr_hold", 32'(bus.out_gnt_addr), 32'(last_id) * 128);
        chk("queue_drained", 32'(q.size()), 32'h0);
    endtask

    task automatic do_rel(input int id);
        logic exp_err = !mb[id];
        @(negedge clk);
        bus.in_rel_wr = 1'b1;
        bus.in_rel_id = 4'(id);
        @(negedge clk);
        bus.in_rel_wr = 1'b0;
        if (!exp_err) mb[id] = 1'b0;
        chk("rel_err", 32'(bus.out_rel_err), 32'(exp_err));
        chk("rel_free", 32'(bus.out_free_count), 32'(free_cnt()));
        chk("rel_busy_map", 32'(bus.out_busy_map), 32'(mb));
        @(negedge clk);
        chk("rel_err_pulse", 32'(bus.out_rel_err), 32'h0);
    endtask

    // Request and release land on the same clock edge; selection sees the old bitmap.
    task automatic alloc_rel(input int port, input int rid);
        logic exp_err = !mb[rid];
        int id = lowest_free();
        exp_t e;
        mb[id] = 1'b1;
        if (!exp_err) mb[rid] = 1'b0;
        e.gnt = 4'(1 << port);
        e.id = 4'(id);
        e.free = 5'(free_cnt());
        q.push_back(e);
        last_id = 4'(id);
        rr = (port + 1) % 4;
        @(negedge clk);
        bus.in_req = 4'(1 << port);
        bus.in_rel_wr = 1'b1;
        bus.in_rel_id = 4'(rid);
        @(negedge clk);
        bus.in_rel_wr = 1'b0;
        chk("same_cycle_rel_err", 32'(bus.out_rel_err), 32'(exp_err));
        drain(20);
        repeat (3) @(negedge clk);
        chk("same_cycle_busy_map", 32'(bus.out_busy_map), 32'(mb));
        chk("same_cycle_free", 32'(bus.out_free_count), 32'(free_cnt()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_req = '0;
        bus.in_rel_wr = 1'b0;
        repeat (2) @(negedge clk);
        mb = '0;
        rr = 0;
        q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int seen;
        rst_n = 1'b0;
        bus.in_req = '0;
        bus.in_rel_wr = 1'b0;
        bus.in_rel_id = '0;
        mb = '0;
        rr = 0;
        last_id = '0;
        #1;
        chk("reset_gnt", 32'(bus.out_gnt), 32'h0);
        chk("reset_gnt_id", 32'(bus.out_gnt_id), 32'h0);
        chk("reset_gnt_addr", 32'(bus.out_gnt_addr), 32'h0);
        chk("reset_free", 32'(bus.out_free_count), 32'd16);
        chk("reset_busy_map", 32'(bus.out_busy_map), 32'h0);
        chk("reset_rel_err", 32'(bus.out_rel_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_round(4'b0001);
        do_reset();
        run_round(4'b1111);

        predict(4'b0001);
        @(negedge clk);
        bus.in_req = 4'b0001;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_reset_busy", 32'(bus.out_busy_map), 32'h0);
        chk("midwait_reset_free", 32'(bus.out_free_count), 32'd16);
        chk("midwait_reset_gnt", 32'(bus.out_gnt), 32'h0);
        chk("midwait_queue", 32'(q.size()), 32'h0);
        bus.in_req = '0;
        mb = '0;
        rr = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_round(4'b0010);

        do_reset();
        repeat (16) run_round(4'b0001);
        @(negedge clk);
        bus.in_req = 4'b0001;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_gnt != 0) seen++;
        end
        chk("no_gnt_when_full", 32'(seen), 32'h0);
        chk("free_zero", 32'(bus.out_free_count), 32'h0);
        e.gnt = 4'b0001;
        e.id = 4'd5;
        e.free = 5'd0;
        q.push_back(e);
        do_rel(5);
        mb[5] = 1'b1;
        rr = 1;
        drain(20);
        repeat (3) @(negedge clk);
        chk("pending_served_busy", 32'(bus.out_busy_map), 32'(mb));
        chk("pending_queue", 32'(q.size()), 32'h0);

        do_rel(3);
        do_rel(3);
        alloc_rel(2, 7);
        alloc_rel(1, 7);

        do_reset();
        for (int r = 0; r < 40; r++) begin
            int nrel = $urandom_range(0, 2);
            for (int j = 0; j < nrel; j++) do_rel($urandom_range(0, 15));
            while (free_cnt() < 4) begin
                int id = $urandom_range(0, 15);
                while (!mb[id]) id = (id + 1) % 16;
                do_rel(id);
            end
            run_round(4'($urandom_range(1, 15)));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
